// File: rtl/hidden_bp_if.sv
// hidden_bp_if
//   Groups the start/operand/result signals of the hidden-layer backward pass.
//   master modport: the producer (drives start and operands, observes results).
//   slave  modport: the hidden_bp engine itself.
// Signals
//   i_start  start pulse
//   i_a      hidden activations, a_j at [j*WIDTH+:WIDTH]
//   i_w      next-layer weights, w_kj at [(k*NUM_PCTN+j)*WIDTH+:WIDTH]
//   i_d      next-layer deltas, d_k at [k*WIDTH+:WIDTH]
//   o_d      hidden deltas, delta_j at [j*WIDTH+:WIDTH]
//   o_valid  one-cycle pulse when o_d is complete
//   o_busy   high while a computation is in flight
interface hidden_bp_if #(
  parameter int NUM_PCTN = 2,
  parameter int NUM_OUT  = 2,
  parameter int WIDTH    = 32
);
  logic                              i_start;
  logic [NUM_PCTN*WIDTH-1:0]         i_a;
  logic [NUM_OUT*NUM_PCTN*WIDTH-1:0] i_w;
  logic [NUM_OUT*WIDTH-1:0]          i_d;
  logic [NUM_PCTN*WIDTH-1:0]         o_d;
  logic                              o_valid;
  logic                              o_busy;

  modport master (
    output i_start, i_a, i_w, i_d,
    input  o_d, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_a, i_w, i_d,
    output o_d, o_valid, o_busy
  );
endinterface

// File: rtl/hidden_bp.sv
// hidden_bp
//   Backward pass of the hidden layer. For each hidden perceptron j it computes
//   delta_j = f'(a_j) * sum_k(w_kj * d_k), with f'(a) = a*(1-a) for a sigmoid,
//   using a single time-shared multiply-accumulate sequenced by an FSM.
// Ports
//   clk   clock, rising edge
//   rst   synchronous reset, active-low
//   bus   hidden_bp_if.slave (start, activations, weights, deltas in;
//         hidden deltas, valid pulse, busy out)
// Configuration
//   HIDDEN_BP_SAT_EN  when defined, each delta saturates to the signed WIDTH
//                     range; otherwise the low WIDTH bits are kept (wrap).
module hidden_bp #(
  parameter int NUM_PCTN = 2,
  parameter int NUM_OUT  = 2,
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24
) (
  input logic       clk,
  input logic       rst,
  hidden_bp_if.slave bus
);

  // Accumulator holds the sum of full-range shifted products so the final
  // narrowing (saturate or wrap) always sees the true mathematical value.
  localparam int ACC_W = 2*WIDTH - FRAC + $clog2(NUM_OUT) + 1;
  localparam int DW    = WIDTH + ACC_W;
  localparam int JW    = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1;
  localparam int KW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(NUM_PCTN-1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_OUT-1);
  localparam logic signed [WIDTH:0] ONE_EXT =
    {{(WIDTH-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, APPLY, DONE} state_e;

  state_e                            state_q;
  logic [NUM_PCTN*WIDTH-1:0]         a_q;
  logic [NUM_OUT*NUM_PCTN*WIDTH-1:0] w_q;
  logic [NUM_OUT*WIDTH-1:0]          d_q;
  logic [JW-1:0]                     j_q;
  logic [KW-1:0]                     k_q;
  logic signed [ACC_W-1:0]           acc_q;
  logic signed [WIDTH-1:0]           fp_q;
  logic [NUM_PCTN*WIDTH-1:0]         od_q;
  logic                              valid_q;
  logic                              busy_q;

  logic signed [WIDTH-1:0]     aSel, wSel, dSel;
  logic signed [2*WIDTH-1:0]   wExt, dExt, wdProd;
  logic signed [WIDTH:0]       aExt, oneMinusA;
  logic signed [2*WIDTH+1:0]   fpA, fpB, fpProd;
  logic signed [DW-1:0]        fpE, accE, deltaFull;
  logic signed [ACC_W-1:0]     prodShift_d, acc_d;
  logic signed [WIDTH-1:0]     fp_d;
  logic [WIDTH-1:0]            delta_d;
`ifdef HIDDEN_BP_SAT_EN
  logic signed [DW-1:0]        deltaShift;
  logic [DW-WIDTH:0]           deltaUpper;
`endif

  // Datapath: operand selection by (j,k), the w*d product shifted back to
  // fixed point, the sigmoid derivative of a_j, and the final delta product.
  // All multiplies use explicitly sign-extended operands so the low bits of
  // the result are the exact full-precision product.
  always_comb begin
    aSel        = a_q[int'(j_q)*WIDTH +: WIDTH];
    wSel        = w_q[(int'(k_q)*NUM_PCTN + int'(j_q))*WIDTH +: WIDTH];
    dSel        = d_q[int'(k_q)*WIDTH +: WIDTH];

    wExt        = {{WIDTH{wSel[WIDTH-1]}}, wSel};
    dExt        = {{WIDTH{dSel[WIDTH-1]}}, dSel};
    wdProd      = wExt * dExt;
    prodShift_d = ACC_W'(wdProd >>> FRAC);
    acc_d       = acc_q + prodShift_d;

    aExt        = {aSel[WIDTH-1], aSel};
    oneMinusA   = ONE_EXT - aExt;
    fpA         = {{(WIDTH+1){aExt[WIDTH]}}, aExt};
    fpB         = {{(WIDTH+1){oneMinusA[WIDTH]}}, oneMinusA};
    fpProd      = fpA * fpB;
    fp_d        = WIDTH'(fpProd >>> FRAC);

    fpE         = {{ACC_W{fp_q[WIDTH-1]}}, fp_q};
    accE        = {{WIDTH{acc_q[ACC_W-1]}}, acc_q};
    deltaFull   = fpE * accE;

`ifdef HIDDEN_BP_SAT_EN
    // In range only when every bit above the WIDTH sign bit matches it.
    deltaShift = deltaFull >>> FRAC;
    deltaUpper = deltaShift[DW-1:WIDTH-1];
    if ((&deltaUpper) || (~|deltaUpper)) begin
      delta_d = deltaShift[WIDTH-1:0];
    end else if (deltaShift[DW-1]) begin
      delta_d = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      delta_d = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    delta_d = WIDTH'(deltaFull >>> FRAC);
`endif
  end

  // Sequencer: IDLE latches operands, MAC walks k for the current j, APPLY
  // writes delta_j, DONE raises the valid pulse and drops busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      w_q     <= '0;
      d_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      fp_q    <= '0;
      od_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            a_q     <= bus.i_a;
            w_q     <= bus.i_w;
            d_q     <= bus.i_d;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          // The derivative only depends on j, so compute it once per neuron.
          if (k_q == '0) begin
            fp_q <= fp_d;
          end
          if (k_q == K_LAST) begin
            state_q <= APPLY;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        APPLY: begin
          od_q[int'(j_q)*WIDTH +: WIDTH] <= delta_d;
          acc_q <= '0;
          k_q   <= '0;
          if (j_q == J_LAST) begin
            state_q <= DONE;
          end else begin
            j_q     <= j_q + JW'(1);
            state_q <= MAC;
          end
        end
        DONE: begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_d     = od_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_hidden_bp.sv
// tb_hidden_bp
//   Directed bench for hidden_bp. Two instances: a 2x1 engine (one next-layer
//   neuron) and the default 2x2 engine. Expected values are hand-computed in
//   Q8.24 fixed point.
module tb_hidden_bp;

  localparam logic [31:0] Q_ONE  = 32'h0100_0000;
  localparam logic [31:0] Q_HALF = 32'h0080_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hidden_bp_if #(.NUM_PCTN(2), .NUM_OUT(1), .WIDTH(32)) ifA ();
  hidden_bp_if #(.NUM_PCTN(2), .NUM_OUT(2), .WIDTH(32)) ifB ();

  hidden_bp #(.NUM_PCTN(2), .NUM_OUT(1), .WIDTH(32), .FRAC(24)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  hidden_bp #(.NUM_PCTN(2), .NUM_OUT(2), .WIDTH(32), .FRAC(24)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the operands of the 2x2 engine (w index = k*2+j).
  task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] w00, input logic [31:0] w01,
                               input logic [31:0] w10, input logic [31:0] w11,
                               input logic [31:0] d0, input logic [31:0] d1);
    ifB.i_a = {a1, a0};
    ifB.i_w = {w11, w10, w01, w00};
    ifB.i_d = {d1, d0};
  endtask

  // Called #1 after an edge; returns #1 after the start edge.
  task automatic pulseStartB();
    ifB.i_start = 1'b1;
    @(posedge clk);
    #1;
    ifB.i_start = 1'b0;
  endtask

  // Counts clocks from the start edge until o_valid; -1 if it never comes.
  task automatic waitValidB(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ifB.o_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat;
  int firstValid;
  int validCount;

  initial begin
    ifA.i_start = 1'b1;
    ifA.i_a     = '0;
    ifA.i_w     = '0;
    ifA.i_d     = '0;
    ifB.i_start = 1'b1;
    applyStimulus(Q_HALF, Q_HALF, Q_ONE, Q_ONE, Q_ONE, Q_ONE, Q_ONE, Q_ONE);

    // Reset held for two clocks with start asserted: everything stays idle.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_odB0",   ifB.o_d[31:0],  32'h0);
    checkOutput("rst_odB1",   ifB.o_d[63:32], 32'h0);
    checkOutput("rst_validB", 32'(ifB.o_valid), 32'h0);
    checkOutput("rst_busyB",  32'(ifB.o_busy),  32'h0);
    checkOutput("rst_validA", 32'(ifA.o_valid), 32'h0);
    checkOutput("rst_busyA",  32'(ifA.o_busy),  32'h0);
    ifA.i_start = 1'b0;
    ifB.i_start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_busyB", 32'(ifB.o_busy), 32'h0);

    // NUM_OUT=1: a=0.5, w=1.0, d=1.0 -> 0.25*1.0 = 0.25, latency 2*2+1 = 5.
    $display("[TB] 2x1 engine, single next-layer delta");
    ifA.i_a = {Q_HALF, Q_HALF};
    ifA.i_w = {Q_ONE, Q_ONE};
    ifA.i_d = Q_ONE;
    ifA.i_start = 1'b1;
    @(posedge clk);
    #1;
    ifA.i_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ifA.o_valid) begin
        lat = n;
        break;
      end
    end
    checkOutput("a_latency", 32'(lat), 32'd5);
    checkOutput("a_od0", ifA.o_d[31:0],  32'h0040_0000);
    checkOutput("a_od1", ifA.o_d[63:32], 32'h0040_0000);

    // 2x2: acc0 = 1*0.5 + (-1)*0.25 = 0.25, acc1 = 2*0.5 + 3*0.25 = 1.75;
    // f'(0.5)=0.25, f'(0)=0 -> delta0 = 0.0625, delta1 = 0; latency 7.
    $display("[TB] 2x2 engine, mixed-sign weights");
    @(posedge clk);
    #1;
    applyStimulus(Q_HALF, 32'h0, Q_ONE, 32'h0200_0000, 32'hFF00_0000,
                  32'h0300_0000, Q_HALF, 32'h0040_0000);
    pulseStartB();
    checkOutput("b_busy_run", 32'(ifB.o_busy), 32'h1);
    waitValidB(lat);
    checkOutput("b_latency", 32'(lat), 32'd7);
    checkOutput("b_od0", ifB.o_d[31:0],  32'h0010_0000);
    checkOutput("b_od1", ifB.o_d[63:32], 32'h0000_0000);
    checkOutput("b_busy_done", 32'(ifB.o_busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("b_valid_pulse", 32'(ifB.o_valid), 32'h0);

    // Large result: a0=0.5, w00=w10=100, d0=d1=50 -> delta0 = 0.25*10000 = 2500.
    $display("[TB] 2x2 engine, out-of-range delta");
    applyStimulus(Q_HALF, 32'h0, 32'h6400_0000, 32'h0, 32'h6400_0000, 32'h0,
                  32'h3200_0000, 32'h3200_0000);
    pulseStartB();
    waitValidB(lat);
    checkOutput("big_latency", 32'(lat), 32'd7);
`ifdef HIDDEN_BP_SAT_EN
    checkOutput("big_od0", ifB.o_d[31:0], 32'h7FFF_FFFF);
`else
    checkOutput("big_od0", ifB.o_d[31:0], 32'hC400_0000);
`endif
    checkOutput("big_od1", ifB.o_d[63:32], 32'h0);

    // Extra starts during the run are ignored and operands are latched at start.
    $display("[TB] 2x2 engine, restart attempts and operand changes mid-run");
    @(posedge clk);
    #1;
    applyStimulus(Q_HALF, 32'h0, Q_ONE, 32'h0200_0000, 32'hFF00_0000,
                  32'h0300_0000, Q_HALF, 32'h0040_0000);
    pulseStartB();
    applyStimulus(Q_HALF, Q_HALF, 32'h6400_0000, Q_ONE, 32'h6400_0000, Q_ONE,
                  32'h3200_0000, 32'h3200_0000);
    firstValid = -1;
    validCount = 0;
    for (int n = 1; n <= 12; n++) begin
      ifB.i_start = (n == 2 || n == 4);
      @(posedge clk);
      #1;
      ifB.i_start = 1'b0;
      if (ifB.o_valid) begin
        validCount++;
        if (firstValid < 0) firstValid = n;
      end
    end
    checkOutput("rs_latency", 32'(firstValid), 32'd7);
    checkOutput("rs_count",   32'(validCount), 32'd1);
    checkOutput("rs_od0", ifB.o_d[31:0],  32'h0010_0000);
    checkOutput("rs_od1", ifB.o_d[63:32], 32'h0000_0000);

    // Reset while in APPLY of neuron 0 (after the second MAC edge).
    $display("[TB] 2x2 engine, reset mid-computation");
    pulseStartB();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("mr_od0",   ifB.o_d[31:0],  32'h0);
    checkOutput("mr_od1",   ifB.o_d[63:32], 32'h0);
    checkOutput("mr_busy",  32'(ifB.o_busy),  32'h0);
    checkOutput("mr_valid", 32'(ifB.o_valid), 32'h0);
    validCount = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (ifB.o_valid) validCount++;
    end
    checkOutput("mr_no_valid", 32'(validCount), 32'd0);

    // Fresh run: a=0.5, all w=1.0, d=0.5 -> acc=1.0, delta = 0.25 for both.
    applyStimulus(Q_HALF, Q_HALF, Q_ONE, Q_ONE, Q_ONE, Q_ONE, Q_HALF, Q_HALF);
    pulseStartB();
    waitValidB(lat);
    checkOutput("fr_latency", 32'(lat), 32'd7);
    checkOutput("fr_od0", ifB.o_d[31:0],  32'h0040_0000);
    checkOutput("fr_od1", ifB.o_d[63:32], 32'h0040_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
